valid_fill_ctrl: RTL and testbench

Load-side consumer of the per-byte valid-bit store. For each load request it drives the store's lookup port, samples the returned per-byte valid bits, and builds a miss mask. It fetches every missing byte from backing memory over a req/ack handshake, then drives the store's write port to mark the access valid and returns a hit/miss response. It sits between the load/store unit and the backing-memory interface.

---
 rtl/valid_fill_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_valid_fill_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/valid_fill_ctrl.sv
// valid_fill_ctrl: load-side lookup of the per-byte valid store, fills
// missing bytes from backing memory, marks them valid and responds.
// Optional fill-ack timeout compiled in with `define FILL_TIMEOUT_EN.
module valid_fill_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] vr_address,
  output logic [1:0]        vr_loadselect,
  output logic              vr_write,
  input  logic              vr_valid_1,
  input  logic              vr_valid_2,
  input  logic              vr_valid_3,
  input  logic              vr_valid_4,
  output logic              fill_req,
  output logic [ADDR_W-1:0] fill_addr,
  input  logic              fill_ack,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [3:0]        resp_miss_mask,
  output logic              resp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_FILL,
    S_FILL_WAIT,
    S_MARK,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [3:0]        mask_q, mask_d;
  logic [3:0]        rem_q, rem_d;
  logic              req_ready_q, req_ready_d;
  logic [ADDR_W-1:0] vr_address_q, vr_address_d;
  logic [1:0]        vr_loadselect_q, vr_loadselect_d;
  logic              vr_write_q, vr_write_d;
  logic              fill_req_q, fill_req_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic [3:0]        resp_mask_q, resp_mask_d;
  logic              resp_err_q, resp_err_d;

`ifdef FILL_TIMEOUT_EN
  localparam logic [15:0] WAIT_LIM = 16'(MAX_WAIT - 1);
  logic [15:0] wait_q, wait_d;
`else
  logic [15:0] unused_max_wait;
  assign unused_max_wait = 16'(MAX_WAIT);
`endif

  logic [3:0] valid_vec;
  logic [3:0] exp_mask;
  logic [3:0] miss;
  logic [1:0] low_idx;
  logic [1:0] size_in;
  logic       go_resp;
  logic       hit_n;
  logic       err_n;

  assign valid_vec = {vr_valid_4, vr_valid_3, vr_valid_2, vr_valid_1};

  // Illegal size 3 is treated as a single byte.
  assign size_in = (req_size == 2'd3) ? 2'd0 : req_size;

  // Bytes covered by the latched access size.
  always_comb begin
    exp_mask = 4'b1111;
    case (size_q)
      2'd0:    exp_mask = 4'b0001;
      2'd1:    exp_mask = 4'b0011;
      default: exp_mask = 4'b1111;
    endcase
  end

  assign miss = exp_mask & ~valid_vec;

  // Lowest outstanding byte is fetched first.
  always_comb begin
    low_idx = 2'd3;
    if (rem_q[0])      low_idx = 2'd0;
    else if (rem_q[1]) low_idx = 2'd1;
    else if (rem_q[2]) low_idx = 2'd2;
    else               low_idx = 2'd3;
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    size_d          = size_q;
    mask_d          = mask_q;
    rem_d           = rem_q;
    vr_address_d    = vr_address_q;
    vr_loadselect_d = vr_loadselect_q;
    vr_write_d      = 1'b0;
    fill_req_d      = fill_req_q;
    fill_addr_d     = fill_addr_q;
    resp_valid_d    = 1'b0;
    resp_hit_d      = 1'b0;
    resp_mask_d     = 4'b0000;
    resp_err_d      = 1'b0;
    go_resp         = 1'b0;
    hit_n           = 1'b0;
    err_n           = 1'b0;
`ifdef FILL_TIMEOUT_EN
    wait_d          = wait_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d          = req_addr;
          size_d          = size_in;
          vr_address_d    = req_addr;
          vr_loadselect_d = size_in;
          state_d         = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        mask_d = miss;
        rem_d  = miss;
        if (miss == 4'b0000) begin
          go_resp = 1'b1;
          hit_n   = 1'b1;
        end else begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        fill_addr_d = addr_q + ADDR_W'(low_idx);
        fill_req_d  = 1'b1;
        state_d     = S_FILL_WAIT;
`ifdef FILL_TIMEOUT_EN
        wait_d      = 16'd0;
`endif
      end
      S_FILL_WAIT: begin
        if (fill_ack) begin
          fill_req_d = 1'b0;
          rem_d      = rem_q & (rem_q - 4'd1);
          if (rem_d != 4'b0000) begin
            state_d = S_FILL;
          end else begin
            state_d         = S_MARK;
            vr_write_d      = 1'b1;
            vr_address_d    = addr_q;
            vr_loadselect_d = size_q;
          end
        end
`ifdef FILL_TIMEOUT_EN
        else if (wait_q == WAIT_LIM) begin
          fill_req_d = 1'b0;
          go_resp    = 1'b1;
          err_n      = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
`endif
      end
      S_MARK: begin
        go_resp = 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (go_resp) begin
      state_d      = S_RESP;
      resp_valid_d = 1'b1;
      resp_hit_d   = hit_n;
      resp_mask_d  = mask_d;
      resp_err_d   = err_n;
    end
    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      size_q          <= 2'd0;
      mask_q          <= 4'b0000;
      rem_q           <= 4'b0000;
      req_ready_q     <= 1'b0;
      vr_address_q    <= '0;
      vr_loadselect_q <= 2'd0;
      vr_write_q      <= 1'b0;
      fill_req_q      <= 1'b0;
      fill_addr_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_mask_q     <= 4'b0000;
      resp_err_q      <= 1'b0;
`ifdef FILL_TIMEOUT_EN
      wait_q          <= 16'd0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      size_q          <= size_d;
      mask_q          <= mask_d;
      rem_q           <= rem_d;
      req_ready_q     <= req_ready_d;
      vr_address_q    <= vr_address_d;
      vr_loadselect_q <= vr_loadselect_d;
      vr_write_q      <= vr_write_d;
      fill_req_q      <= fill_req_d;
      fill_addr_q     <= fill_addr_d;
      resp_valid_q    <= resp_valid_d;
      resp_hit_q      <= resp_hit_d;
      resp_mask_q     <= resp_mask_d;
      resp_err_q      <= resp_err_d;
`ifdef FILL_TIMEOUT_EN
      wait_q          <= wait_d;
`endif
    end
  end

  assign req_ready      = req_ready_q;
  assign vr_address     = vr_address_q;
  assign vr_loadselect  = vr_loadselect_q;
  assign vr_write       = vr_write_q;
  assign fill_req       = fill_req_q;
  assign fill_addr      = fill_addr_q;
  assign resp_valid     = resp_valid_q;
  assign resp_hit       = resp_hit_q;
  assign resp_miss_mask = resp_mask_q;
  assign resp_err       = resp_err_q;

endmodule

// File: tb/tb_valid_fill_ctrl.sv
// tb_valid_fill_ctrl: directed checks of lookup, fill, mark and response.
// Timeout scenario runs only when FILL_TIMEOUT_EN is defined.
module tb_valid_fill_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_addr;
  logic [1:0] req_size;
  logic [9:0] vr_address;
  logic [1:0] vr_loadselect;
  logic       vr_write;
  logic       vr_valid_1;
  logic       vr_valid_2;
  logic       vr_valid_3;
  logic       vr_valid_4;
  logic       fill_req;
  logic [9:0] fill_addr;
  logic       fill_ack;
  logic       resp_valid;
  logic       resp_hit;
  logic [3:0] resp_miss_mask;
  logic       resp_err;

  int n_checks = 0;
  int n_err    = 0;

  valid_fill_ctrl #(
    .ADDR_W   (10),
    .MAX_WAIT (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_size       (req_size),
    .vr_address     (vr_address),
    .vr_loadselect  (vr_loadselect),
    .vr_write       (vr_write),
    .vr_valid_1     (vr_valid_1),
    .vr_valid_2     (vr_valid_2),
    .vr_valid_3     (vr_valid_3),
    .vr_valid_4     (vr_valid_4),
    .fill_req       (fill_req),
    .fill_addr      (fill_addr),
    .fill_ack       (fill_ack),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .resp_miss_mask (resp_miss_mask),
    .resp_err       (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_v(input logic [3:0] v);
    {vr_valid_4, vr_valid_3, vr_valid_2, vr_valid_1} = v;
  endtask

  // Present a request in IDLE; returns in the LOOKUP cycle.
  task automatic issue(input logic [9:0] a, input logic [1:0] s,
                       input logic [1:0] ls_exp);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    step();
    req_valid = 1'b0;
    chk("lookup_addr", 32'(vr_address), 32'(a));
    chk("lookup_size", 32'(vr_loadselect), 32'(ls_exp));
    chk("lookup_ready", 32'(req_ready), 32'd0);
  endtask

  // Starting in FILL, wait for fill_req, check address, ack after
  // 'extra' further cycles of fill_req.
  task automatic do_fill(input string tag, input logic [9:0] a,
                         input int extra);
    int n;
    n = 0;
    while (!fill_req && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_req_seen"}, 32'(fill_req), 32'd1);
    chk({tag, "_addr"}, 32'(fill_addr), 32'(a));
    for (int i = 0; i < extra; i++) begin
      step();
      chk({tag, "_hold"}, 32'(fill_req), 32'd1);
      chk({tag, "_hold_addr"}, 32'(fill_addr), 32'(a));
    end
    fill_ack = 1'b1;
    step();
    fill_ack = 1'b0;
    chk({tag, "_drop"}, 32'(fill_req), 32'd0);
  endtask

  initial begin
    int n;
    int wr_seen;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_size  = 2'd0;
    fill_ack  = 1'b0;
    set_v(4'b0000);
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_fill_req", 32'(fill_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_vr_write", 32'(vr_write), 32'd0);
    chk("rst_vr_addr", 32'(vr_address), 32'd0);
    rst = 1'b1;
    step();

    // 1: all bytes valid, word hit
    set_v(4'b1111);
    issue(10'h010, 2'd2, 2'd2);
    step();
    chk("t1_check_no_fill", 32'(fill_req), 32'd0);
    step();
    chk("t1_resp_valid", 32'(resp_valid), 32'd1);
    chk("t1_resp_hit", 32'(resp_hit), 32'd1);
    chk("t1_resp_mask", 32'(resp_miss_mask), 32'h0);
    chk("t1_no_write", 32'(vr_write), 32'd0);
    chk("t1_no_fill", 32'(fill_req), 32'd0);
    step();
    chk("t1_resp_pulse", 32'(resp_valid), 32'd0);

    // 2: halfword, byte +1 missing
    set_v(4'b0001);
    issue(10'h020, 2'd1, 2'd1);
    step();
    step();
    do_fill("t2_fill", 10'h021, 0);
    chk("t2_mark_write", 32'(vr_write), 32'd1);
    chk("t2_mark_addr", 32'(vr_address), 32'h020);
    chk("t2_mark_size", 32'(vr_loadselect), 32'd1);
    step();
    chk("t2_resp_valid", 32'(resp_valid), 32'd1);
    chk("t2_resp_hit", 32'(resp_hit), 32'd0);
    chk("t2_resp_mask", 32'(resp_miss_mask), 32'h2);
    chk("t2_resp_err", 32'(resp_err), 32'd0);
    chk("t2_write_done", 32'(vr_write), 32'd0);
    step();

    // 3: word crossing the top of the address space
    set_v(4'b0000);
    issue(10'h3FE, 2'd2, 2'd2);
    step();
    step();
    do_fill("t3_b0", 10'h3FE, 1);
    do_fill("t3_b1", 10'h3FF, 1);
    do_fill("t3_b2", 10'h000, 1);
    do_fill("t3_b3", 10'h001, 1);
    chk("t3_mark_write", 32'(vr_write), 32'd1);
    chk("t3_mark_addr", 32'(vr_address), 32'h3FE);
    step();
    chk("t3_resp_valid", 32'(resp_valid), 32'd1);
    chk("t3_resp_mask", 32'(resp_miss_mask), 32'hF);
    chk("t3_resp_hit", 32'(resp_hit), 32'd0);
    step();

    // 4: illegal size behaves as byte
    set_v(4'b1110);
    issue(10'h005, 2'd3, 2'd0);
    step();
    step();
    do_fill("t4_fill", 10'h005, 0);
    chk("t4_mark_write", 32'(vr_write), 32'd1);
    chk("t4_mark_size", 32'(vr_loadselect), 32'd0);
    chk("t4_mark_addr", 32'(vr_address), 32'h005);
    step();
    chk("t4_resp_mask", 32'(resp_miss_mask), 32'h1);
    chk("t4_resp_valid", 32'(resp_valid), 32'd1);
    step();

    // 5: reset while a fill is outstanding
    set_v(4'b0000);
    issue(10'h100, 2'd0, 2'd0);
    step();
    step();
    step();
    chk("t5_fill_up", 32'(fill_req), 32'd1);
    rst = 1'b0;
    step();
    chk("t5_rst_fill_req", 32'(fill_req), 32'd0);
    chk("t5_rst_fill_addr", 32'(fill_addr), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_vr_addr", 32'(vr_address), 32'd0);
    chk("t5_rst_resp", 32'(resp_valid), 32'd0);
    rst      = 1'b1;
    fill_ack = 1'b1;
    step();
    chk("t5_ready_back", 32'(req_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (resp_valid || fill_req || vr_write) n++;
    end
    chk("t5_late_ack_ignored", 32'(n), 32'd0);
    fill_ack = 1'b0;
    set_v(4'b1111);
    issue(10'h030, 2'd0, 2'd0);
    step();
    step();
    chk("t5_recover_resp", 32'(resp_valid), 32'd1);
    chk("t5_recover_hit", 32'(resp_hit), 32'd1);
    step();

`ifdef FILL_TIMEOUT_EN
    // 6: fill ack never arrives
    set_v(4'b0000);
    issue(10'h040, 2'd0, 2'd0);
    step();
    step();
    step();
    chk("t6_fill_up", 32'(fill_req), 32'd1);
    n       = 0;
    wr_seen = 0;
    while (fill_req && n < 20) begin
      step();
      n++;
      if (vr_write) wr_seen++;
    end
    chk("t6_req_cycles", 32'(n), 32'd8);
    chk("t6_no_write", 32'(wr_seen), 32'd0);
    chk("t6_resp_valid", 32'(resp_valid), 32'd1);
    chk("t6_resp_err", 32'(resp_err), 32'd1);
    chk("t6_resp_hit", 32'(resp_hit), 32'd0);
    chk("t6_resp_mask", 32'(resp_miss_mask), 32'h1);
    step();
    chk("t6_ready", 32'(req_ready), 32'd1);
`else
    wr_seen = 0;
    chk("no_timeout_err", 32'(resp_err + 1'(wr_seen)), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
